// File: rtl/dds_pkg.sv
// Shared types and default sizing for the DDS sweep controller.
// The DDS_TRIANGLE_SWEEP_EN macro (see dds_ftw_stepper) selects triangle vs. sawtooth sweeps.
package dds_pkg;

    localparam int FTW_W_DEFAULT      = 32;
    localparam int DWELL_W_DEFAULT    = 16;
    localparam int SETTLE_MAX_DEFAULT = 255;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SETTLE = 3'd2,
        DWELL  = 3'd3,
        STEP   = 3'd4
    } state_t;

endpackage

// File: rtl/dds_ftw_stepper.sv
// Next-FTW calculation: overflow-safe increment, clamp to the stop bound, and pass-complete flag.
// With DDS_TRIANGLE_SWEEP_EN defined it also walks back down to start with underflow detection.
module dds_ftw_stepper
    import dds_pkg::*;
#(
    parameter int FTW_W = FTW_W_DEFAULT
) (
    input  logic [FTW_W-1:0] cur,
    input  logic [FTW_W-1:0] start,
    input  logic [FTW_W-1:0] step,
    input  logic [FTW_W-1:0] stop,
`ifdef DDS_TRIANGLE_SWEEP_EN
    input  logic             dir,
    output logic             dir_next,
`endif
    output logic [FTW_W-1:0] nxt,
    output logic             last
);

    logic [FTW_W:0] sum;
    logic           up_last;

    // The extra sum bit catches wrap-around so a wrapped FTW is never offered.
    always_comb begin
        sum     = {1'b0, cur} + {1'b0, step};
        up_last = sum[FTW_W] || (sum[FTW_W-1:0] > stop) || (step == '0) || (cur >= stop);
    end

`ifdef DDS_TRIANGLE_SWEEP_EN
    logic [FTW_W:0] diff;
    logic           down_ok;

    // dir: 0 = rising, 1 = falling. Turn-around points are never repeated.
    always_comb begin
        diff     = {1'b0, cur} - {1'b0, step};
        down_ok  = !diff[FTW_W] && (diff[FTW_W-1:0] >= start) && (cur > start);
        nxt      = start;
        last     = 1'b0;
        dir_next = dir;
        if (!dir) begin
            if (!up_last) begin
                nxt = sum[FTW_W-1:0];
            end else if (cur == start) begin
                last = 1'b1;
            end else if (down_ok) begin
                nxt      = diff[FTW_W-1:0];
                dir_next = 1'b1;
            end else begin
                dir_next = 1'b1;
            end
        end else begin
            if (down_ok) begin
                nxt = diff[FTW_W-1:0];
            end else if (cur > start) begin
                nxt = start;
            end else begin
                // Back at start: a continuous sweep rises again from here.
                last     = 1'b1;
                dir_next = 1'b0;
                nxt      = up_last ? start : sum[FTW_W-1:0];
            end
        end
    end
`else
    always_comb begin
        nxt  = up_last ? start : sum[FTW_W-1:0];
        last = up_last;
    end
`endif

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear FTW sweep sequencer: load, wait for stable DDS output, dwell, advance.
// Build option DDS_TRIANGLE_SWEEP_EN adds a rising/falling direction bit (triangle sweep).
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int FTW_W      = FTW_W_DEFAULT,
    parameter int DWELL_W    = DWELL_W_DEFAULT,
    parameter int SETTLE_MAX = SETTLE_MAX_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_sys,
    input  logic               cfg_start,
    input  logic [FTW_W-1:0]   cfg_ftw_start,
    input  logic [FTW_W-1:0]   cfg_ftw_step,
    input  logic [FTW_W-1:0]   cfg_ftw_stop,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_continuous,
    input  logic               abort,
    input  logic               noise_en,
    output logic [FTW_W-1:0]   ftw_out,
    output logic               ftw_load,
    output logic               busy,
    output logic               point_tick,
    output logic               sweep_done,
    output logic               err_timeout
);

    localparam int SET_W = $clog2(SETTLE_MAX + 1);

    state_t             state_reg, state_next;
    logic [FTW_W-1:0]   cur_reg, cur_next;
    logic [FTW_W-1:0]   ftw_out_reg, ftw_out_next;
    logic [FTW_W-1:0]   start_reg, start_next;
    logic [FTW_W-1:0]   step_reg, step_next;
    logic [FTW_W-1:0]   stop_reg, stop_next;
    logic [DWELL_W-1:0] dwell_reg, dwell_next;
    logic               cont_reg, cont_next;
    logic [DWELL_W-1:0] dwell_cnt_reg, dwell_cnt_next;
    logic [SET_W-1:0]   settle_cnt_reg, settle_cnt_next;
    logic               ftw_load_reg, ftw_load_next;
    logic               point_tick_reg, point_tick_next;
    logic               sweep_done_reg, sweep_done_next;
    logic               err_reg, err_next;
    logic [FTW_W-1:0]   stepper_nxt;
    logic               stepper_last;

`ifdef DDS_TRIANGLE_SWEEP_EN
    logic dir_reg, dir_next, stepper_dir;
`endif

    dds_ftw_stepper #(
        .FTW_W (FTW_W)
    ) u_stepper (
        .cur      (cur_reg),
        .start    (start_reg),
        .step     (step_reg),
        .stop     (stop_reg),
`ifdef DDS_TRIANGLE_SWEEP_EN
        .dir      (dir_reg),
        .dir_next (stepper_dir),
`endif
        .nxt      (stepper_nxt),
        .last     (stepper_last)
    );

    always_ff @(posedge clk) begin
        if (rst_sys) begin
            state_reg      <= IDLE;
            cur_reg        <= '0;
            ftw_out_reg    <= '0;
            start_reg      <= '0;
            step_reg       <= '0;
            stop_reg       <= '0;
            dwell_reg      <= '0;
            cont_reg       <= 1'b0;
            dwell_cnt_reg  <= '0;
            settle_cnt_reg <= '0;
            ftw_load_reg   <= 1'b0;
            point_tick_reg <= 1'b0;
            sweep_done_reg <= 1'b0;
            err_reg        <= 1'b0;
`ifdef DDS_TRIANGLE_SWEEP_EN
            dir_reg        <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            cur_reg        <= cur_next;
            ftw_out_reg    <= ftw_out_next;
            start_reg      <= start_next;
            step_reg       <= step_next;
            stop_reg       <= stop_next;
            dwell_reg      <= dwell_next;
            cont_reg       <= cont_next;
            dwell_cnt_reg  <= dwell_cnt_next;
            settle_cnt_reg <= settle_cnt_next;
            ftw_load_reg   <= ftw_load_next;
            point_tick_reg <= point_tick_next;
            sweep_done_reg <= sweep_done_next;
            err_reg        <= err_next;
`ifdef DDS_TRIANGLE_SWEEP_EN
            dir_reg        <= dir_next;
`endif
        end
    end

    always_comb begin
        state_next      = state_reg;
        cur_next        = cur_reg;
        ftw_out_next    = ftw_out_reg;
        start_next      = start_reg;
        step_next       = step_reg;
        stop_next       = stop_reg;
        dwell_next      = dwell_reg;
        cont_next       = cont_reg;
        dwell_cnt_next  = dwell_cnt_reg;
        settle_cnt_next = settle_cnt_reg;
        ftw_load_next   = 1'b0;
        point_tick_next = 1'b0;
        sweep_done_next = 1'b0;
        err_next        = err_reg;
`ifdef DDS_TRIANGLE_SWEEP_EN
        dir_next        = dir_reg;
`endif

        // abort in IDLE also suppresses a coincident cfg_start.
        if (abort && (state_reg != IDLE)) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cfg_start && !abort) begin
                        start_next      = cfg_ftw_start;
                        step_next       = cfg_ftw_step;
                        stop_next       = cfg_ftw_stop;
                        dwell_next      = cfg_dwell;
                        cont_next       = cfg_continuous;
                        cur_next        = cfg_ftw_start;
                        err_next        = 1'b0;
                        dwell_cnt_next  = '0;
                        settle_cnt_next = '0;
`ifdef DDS_TRIANGLE_SWEEP_EN
                        dir_next        = 1'b0;
`endif
                        state_next      = LOAD;
                    end
                end
                LOAD: begin
                    ftw_out_next    = cur_reg;
                    ftw_load_next   = 1'b1;
                    settle_cnt_next = '0;
                    state_next      = SETTLE;
                end
                SETTLE: begin
                    if (noise_en) begin
                        dwell_cnt_next = (dwell_reg == '0) ? '0 : dwell_reg - DWELL_W'(1);
                        state_next     = DWELL;
                    end else if (settle_cnt_reg == SET_W'(SETTLE_MAX - 1)) begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        settle_cnt_next = settle_cnt_reg + SET_W'(1);
                    end
                end
                DWELL: begin
                    // Losing stability restarts both the settle wait and the full dwell.
                    if (!noise_en) begin
                        settle_cnt_next = '0;
                        state_next      = SETTLE;
                    end else if (dwell_cnt_reg == '0) begin
                        point_tick_next = 1'b1;
                        state_next      = STEP;
                    end else begin
                        dwell_cnt_next = dwell_cnt_reg - DWELL_W'(1);
                    end
                end
                STEP: begin
                    if (stepper_last && !cont_reg) begin
                        sweep_done_next = 1'b1;
                        state_next      = IDLE;
                    end else begin
                        cur_next   = stepper_nxt;
`ifdef DDS_TRIANGLE_SWEEP_EN
                        dir_next   = stepper_dir;
`endif
                        state_next = LOAD;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign ftw_out     = ftw_out_reg;
    assign ftw_load    = ftw_load_reg;
    assign busy        = (state_reg != IDLE);
    assign point_tick  = point_tick_reg;
    assign sweep_done  = sweep_done_reg;
    assign err_timeout = err_reg;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: vector table of single-pass sweeps plus hand-written
// sequences for settle timeout, continuous/abort, noise drop mid-dwell and reset mid-sweep.
module tb_dds_sweep_ctrl;

    logic        clk;
    logic        rst_sys;
    logic        cfg_start;
    logic [31:0] cfg_ftw_start;
    logic [31:0] cfg_ftw_step;
    logic [31:0] cfg_ftw_stop;
    logic [15:0] cfg_dwell;
    logic        cfg_continuous;
    logic        abort;
    logic        noise_en;
    logic [31:0] ftw_out;
    logic        ftw_load;
    logic        busy;
    logic        point_tick;
    logic        sweep_done;
    logic        err_timeout;

    dds_sweep_ctrl dut (
        .clk            (clk),
        .rst_sys        (rst_sys),
        .cfg_start      (cfg_start),
        .cfg_ftw_start  (cfg_ftw_start),
        .cfg_ftw_step   (cfg_ftw_step),
        .cfg_ftw_stop   (cfg_ftw_stop),
        .cfg_dwell      (cfg_dwell),
        .cfg_continuous (cfg_continuous),
        .abort          (abort),
        .noise_en       (noise_en),
        .ftw_out        (ftw_out),
        .ftw_load       (ftw_load),
        .busy           (busy),
        .point_tick     (point_tick),
        .sweep_done     (sweep_done),
        .err_timeout    (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] start;
        logic [31:0] step;
        logic [31:0] stop;
        logic [15:0] dwell;
        int          n;
        logic [31:0] exp_ftw [8];
    } vec_t;

    vec_t        vecs [8];
    int          n_vecs = 0;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          c0 = 0;
    logic [31:0] load_q [$];
    int          first_load_cyc, first_tick_cyc, last_tick_cyc, done_cyc;
    int          tick_cnt, done_cnt;
    logic        overlap;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_rec();
        load_q.delete();
        first_load_cyc = -1;
        first_tick_cyc = -1;
        last_tick_cyc  = -1;
        done_cyc       = -1;
        tick_cnt       = 0;
        done_cnt       = 0;
        overlap        = 1'b0;
    endtask

    // Advance one clock and log the registered pulses seen after that edge.
    task automatic step_clk();
        @(posedge clk);
        #1;
        cyc++;
        if (ftw_load) begin
            load_q.push_back(ftw_out);
            if (first_load_cyc < 0) first_load_cyc = cyc;
        end
        if (point_tick) begin
            tick_cnt++;
            last_tick_cyc = cyc;
            if (first_tick_cyc < 0) first_tick_cyc = cyc;
        end
        if (sweep_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if ((int'(ftw_load) + int'(point_tick) + int'(sweep_done)) > 1) overlap = 1'b1;
    endtask

    // Issue cfg_start, then scramble cfg_* to prove the plan was latched.
    task automatic start_sweep(input logic [31:0] s, input logic [31:0] st, input logic [31:0] sp,
                               input logic [15:0] d, input logic cont);
        cfg_ftw_start  = s;
        cfg_ftw_step   = st;
        cfg_ftw_stop   = sp;
        cfg_dwell      = d;
        cfg_continuous = cont;
        cfg_start      = 1'b1;
        clear_rec();
        step_clk();
        cfg_start      = 1'b0;
        c0             = cyc;
        cfg_ftw_start  = 32'h1234_5678;
        cfg_ftw_step   = 32'd1;
        cfg_ftw_stop   = 32'hFFFF_FFFF;
        cfg_dwell      = 16'd40;
        cfg_continuous = ~cont;
    endtask

    task automatic add_vec(input logic [31:0] s, input logic [31:0] st, input logic [31:0] sp,
                           input logic [15:0] d, input int n, input logic [31:0] e [8]);
        vecs[n_vecs].start   = s;
        vecs[n_vecs].step    = st;
        vecs[n_vecs].stop    = sp;
        vecs[n_vecs].dwell   = d;
        vecs[n_vecs].n       = n;
        vecs[n_vecs].exp_ftw = e;
        n_vecs++;
    endtask

    task automatic run_vec(input int idx);
        int dl;
        dl = (vecs[idx].dwell == 16'd0) ? 1 : int'(vecs[idx].dwell);
        start_sweep(vecs[idx].start, vecs[idx].step, vecs[idx].stop, vecs[idx].dwell, 1'b0);
        check($sformatf("v%0d_busy_start", idx), {31'd0, busy}, 32'd1);
        for (int k = 0; k < 400 && done_cnt == 0; k++) step_clk();
        step_clk();
        check($sformatf("v%0d_load_count", idx), load_q.size(), vecs[idx].n);
        for (int j = 0; j < vecs[idx].n && j < load_q.size(); j++)
            check($sformatf("v%0d_ftw%0d", idx, j), load_q[j], vecs[idx].exp_ftw[j]);
        check($sformatf("v%0d_ticks", idx), tick_cnt, vecs[idx].n);
        check($sformatf("v%0d_done_count", idx), done_cnt, 32'd1);
        check($sformatf("v%0d_done_after_step", idx), done_cyc, last_tick_cyc + 1);
        check($sformatf("v%0d_busy_end", idx), {31'd0, busy}, 32'd0);
        check($sformatf("v%0d_overlap", idx), {31'd0, overlap}, 32'd0);
        check($sformatf("v%0d_load_latency", idx), first_load_cyc, c0 + 1);
        check($sformatf("v%0d_tick_latency", idx), first_tick_cyc, c0 + 2 + dl);
        $display("vec %0d start=0x%0h step=0x%0h stop=0x%0h dwell=%0d loads=%0d ticks=%0d",
                 idx, vecs[idx].start, vecs[idx].step, vecs[idx].stop, vecs[idx].dwell,
                 load_q.size(), tick_cnt);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] cont_exp [5];
        int          err_cyc;

        rst_sys = 1'b1; cfg_start = 1'b0; abort = 1'b0; noise_en = 1'b1;
        cfg_ftw_start = '0; cfg_ftw_step = '0; cfg_ftw_stop = '0;
        cfg_dwell = '0; cfg_continuous = 1'b0;
        clear_rec();
        repeat (3) step_clk();
        check("rst_ftw_out", ftw_out, 32'd0);
        check("rst_ftw_load", {31'd0, ftw_load}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_point_tick", {31'd0, point_tick}, 32'd0);
        check("rst_sweep_done", {31'd0, sweep_done}, 32'd0);
        check("rst_err", {31'd0, err_timeout}, 32'd0);
        rst_sys = 1'b0;
        step_clk();

`ifdef DDS_TRIANGLE_SWEEP_EN
        add_vec(32'd100, 32'd50, 32'd250, 16'd3, 7, '{100, 150, 200, 250, 200, 150, 100, 0});
        add_vec(32'hFFFF_FFF0, 32'h20, 32'hFFFF_FFFF, 16'd1, 1, '{32'hFFFF_FFF0, 0, 0, 0, 0, 0, 0, 0});
        add_vec(32'd300, 32'd10, 32'd200, 16'd0, 1, '{300, 0, 0, 0, 0, 0, 0, 0});
        add_vec(32'd5, 32'd0, 32'd100, 16'd2, 1, '{5, 0, 0, 0, 0, 0, 0, 0});
        add_vec(32'd0, 32'd7, 32'd20, 16'd0, 5, '{0, 7, 14, 7, 0, 0, 0, 0});
        add_vec(32'hFFFF_FF00, 32'h80, 32'hFFFF_FFFF, 16'd1, 3,
                '{32'hFFFF_FF00, 32'hFFFF_FF80, 32'hFFFF_FF00, 0, 0, 0, 0, 0});
        add_vec(32'd0, 32'd100, 32'd300, 16'd1, 7, '{0, 100, 200, 300, 200, 100, 0, 0});
        cont_exp = '{10, 20, 30, 20, 10};
`else
        add_vec(32'd100, 32'd50, 32'd250, 16'd3, 4, '{100, 150, 200, 250, 0, 0, 0, 0});
        add_vec(32'hFFFF_FFF0, 32'h20, 32'hFFFF_FFFF, 16'd1, 1, '{32'hFFFF_FFF0, 0, 0, 0, 0, 0, 0, 0});
        add_vec(32'd300, 32'd10, 32'd200, 16'd0, 1, '{300, 0, 0, 0, 0, 0, 0, 0});
        add_vec(32'd5, 32'd0, 32'd100, 16'd2, 1, '{5, 0, 0, 0, 0, 0, 0, 0});
        add_vec(32'd0, 32'd7, 32'd20, 16'd0, 3, '{0, 7, 14, 0, 0, 0, 0, 0});
        add_vec(32'hFFFF_FF00, 32'h80, 32'hFFFF_FFFF, 16'd1, 2,
                '{32'hFFFF_FF00, 32'hFFFF_FF80, 0, 0, 0, 0, 0, 0});
        add_vec(32'd0, 32'd100, 32'd300, 16'd1, 4, '{0, 100, 200, 300, 0, 0, 0, 0});
        cont_exp = '{10, 20, 30, 10, 20};
`endif

        for (int i = 0; i < n_vecs; i++) run_vec(i);

        // Settle timeout: 255 low cycles in SETTLE, flag visible the cycle after.
        noise_en = 1'b0;
        start_sweep(32'd1000, 32'd1, 32'd2000, 16'd1, 1'b0);
        err_cyc = -1;
        for (int k = 0; k < 400 && err_cyc < 0; k++) begin
            step_clk();
            if (err_timeout) err_cyc = cyc;
        end
        check("timeout_cycle", err_cyc, c0 + 256);
        check("timeout_busy", {31'd0, busy}, 32'd0);
        check("timeout_ftw_held", ftw_out, 32'd1000);
        check("timeout_loads", load_q.size(), 32'd1);
        step_clk();
        check("timeout_sticky", {31'd0, err_timeout}, 32'd1);
        start_sweep(32'd1000, 32'd1, 32'd2000, 16'd1, 1'b0);
        check("timeout_cleared", {31'd0, err_timeout}, 32'd0);
        abort = 1'b1;
        step_clk();
        abort = 1'b0;
        noise_en = 1'b1;
        $display("timeout seq: err_cycle_offset=%0d", err_cyc - c0);

        // Continuous sweep, then abort while dwelling.
        start_sweep(32'd10, 32'd10, 32'd30, 16'd2, 1'b1);
        for (int k = 0; k < 200 && load_q.size() < 5; k++) step_clk();
        check("cont_load_count", load_q.size(), 32'd5);
        for (int j = 0; j < 5 && j < load_q.size(); j++)
            check($sformatf("cont_ftw%0d", j), load_q[j], cont_exp[j]);
        check("cont_no_done", done_cnt, 32'd0);
        step_clk();
        abort = 1'b1;
        clear_rec();
        step_clk();
        abort = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_ftw_held", ftw_out, cont_exp[4]);
        repeat (10) step_clk();
        check("abort_no_load", load_q.size(), 32'd0);
        check("abort_no_tick", tick_cnt, 32'd0);
        check("abort_no_done", done_cnt, 32'd0);
        cfg_start = 1'b1;
        abort = 1'b1;
        step_clk();
        cfg_start = 1'b0;
        abort = 1'b0;
        check("start_with_abort_ignored", {31'd0, busy}, 32'd0);
        $display("continuous/abort seq: ftw_out=0x%0h", ftw_out);

        // noise_en low for two edges mid-dwell restarts the full dwell.
        start_sweep(32'd500, 32'd1, 32'd500, 16'd5, 1'b0);
        repeat (3) step_clk();
        noise_en = 1'b0;
        repeat (2) step_clk();
        noise_en = 1'b1;
        for (int k = 0; k < 100 && done_cnt == 0; k++) step_clk();
        check("noise_tick_cycle", first_tick_cyc, c0 + 11);
        check("noise_tick_count", tick_cnt, 32'd1);
        check("noise_done_cycle", done_cyc, c0 + 12);
        check("noise_loads", load_q.size(), 32'd1);
        $display("noise-drop seq: tick_offset=%0d", first_tick_cyc - c0);

        // Reset mid-dwell clears everything with no pulse.
        start_sweep(32'd100, 32'd50, 32'd250, 16'd3, 1'b0);
        repeat (2) step_clk();
        rst_sys = 1'b1;
        step_clk();
        rst_sys = 1'b0;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_ftw_out", ftw_out, 32'd0);
        check("midrst_ftw_load", {31'd0, ftw_load}, 32'd0);
        check("midrst_tick", {31'd0, point_tick}, 32'd0);
        check("midrst_done", {31'd0, sweep_done}, 32'd0);
        $display("mid-sweep reset seq: busy=%0d ftw_out=0x%0h", busy, ftw_out);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
Sequences the DDS phase accumulator through a linear frequency sweep. It latches a start/step/stop frequency-tuning-word (FTW) plan and loads each FTW into the DDS. It then waits for the sine path to report stable (noise_en), dwells a programmed number of clk cycles, and advances. It sits between the host/config registers and the DDS core, alongside rst_gen, and runs off the same clk and rst_sys.

Parameters:
FTW_W, 32, width of frequency tuning words.
DWELL_W, 16, width of the dwell counter.
SETTLE_MAX, 255, settle timeout in clk cycles; if noise_en stays low this long, err_timeout is raised.

Ports:
clk  input  1  system clock.
rst_sys  input  1  synchronous, active-high reset.
cfg_start  input  1  one-cycle pulse that starts a sweep; ignored while busy.
cfg_ftw_start  input  FTW_W  first FTW.
cfg_ftw_step  input  FTW_W  increment per point (unsigned).
cfg_ftw_stop  input  FTW_W  last FTW (inclusive bound).
cfg_dwell  input  DWELL_W  dwell cycles per point; 0 is treated as 1.
cfg_continuous  input  1  1 = restart from start after the last point; 0 = single pass.
abort  input  1  stop the sweep immediately.
noise_en  input  1  DDS output stable (from rst_gen).
ftw_out  output  FTW_W  FTW driven to the DDS core.
ftw_load  output  1  one-cycle pulse; the DDS captures ftw_out on it.
busy  output  1  high from the cycle after cfg_start acceptance until return to IDLE.
point_tick  output  1  one-cycle pulse at the end of each dwell.
sweep_done  output  1  one-cycle pulse when a single pass completes.
err_timeout  output  1  sticky; cleared by rst_sys or the next accepted cfg_start.

Behaviour:
- Reset (rst_sys=1 at a clk edge):
  - state=IDLE; ftw_out=0; ftw_load=0; busy=0; point_tick=0; sweep_done=0; err_timeout=0; counters=0.
  - rst_sys asserted mid-sweep has the same effect; no pulse is emitted in that cycle.
- Config latch: cfg_start in IDLE latches all cfg_* into shadow registers. cfg_* changes after that have no effect until the next start.
- States:
  - IDLE: on cfg_start, cur<=cfg_ftw_start and go to LOAD.
  - LOAD (1 cycle): ftw_out<=cur and ftw_load=1; go to SETTLE.
  - SETTLE: wait for noise_en=1, then go to DWELL with the dwell counter loaded to max(cfg_dwell,1)-1. Count settle cycles; if the count reaches SETTLE_MAX, set err_timeout and go to IDLE (ftw_out holds).
  - DWELL: count down to 0. At 0, pulse point_tick and go to STEP.
    - If noise_en drops during DWELL, return to SETTLE with the settle count reset.
  - STEP (1 cycle): compute nxt=cur+step with a FTW_W+1-bit sum.
    - Last point if: carry-out set, OR nxt>stop, OR step==0, OR cur>=stop.
    - Not last: cur<=nxt, go to LOAD.
    - Last and cfg_continuous=1: cur<=start, go to LOAD.
    - Last and cfg_continuous=0: pulse sweep_done, go to IDLE.
- Clamping: FTW never exceeds stop, and is never loaded from a wrapped sum. If start>stop, exactly one point (start) is produced.
- Latency: cfg_start at cycle N gives ftw_load at N+2 (IDLE→LOAD at N+1, pulse registered at N+2). With noise_en already high, the first point_tick occurs at N+3+dwell.
- abort: highest priority after rst_sys, in any non-IDLE state. Next cycle state=IDLE; no sweep_done, point_tick or ftw_load is emitted; ftw_out holds its last value.
- cfg_start and abort in the same cycle in IDLE: start is ignored.
- ftw_load, point_tick and sweep_done are registered, one clk wide, and never overlap.

Optional Feature:
DDS_TRIANGLE_SWEEP_EN.
- Defined: adds a direction bit.
  - On reaching the last point upward, the sweep reverses and decrements by step down to start (clamped, with underflow detection), producing a triangle sweep.
  - In single-pass mode, sweep_done pulses after returning to start.
  - The turn-around points (start and stop) are loaded once, not repeated.
- Undefined: upward sawtooth only, as above; the direction logic is absent.

Decomposition:
- Package dds_pkg: state enum (IDLE, LOAD, SETTLE, DWELL, STEP); default widths FTW_W/DWELL_W; SETTLE_MAX default.
- One natural sub-module: dds_ftw_stepper, the combinational/registered next-FTW calculation with clamp and last-point flag, including the triangle direction when enabled. The FSM stays in dds_sweep_ctrl.

Test Plan:
- start=100, step=50, stop=250, dwell=3, single, noise_en=1 → ftw_load values 100, 150, 200, 250; 4 point_ticks; sweep_done one cycle after the last STEP; busy falls afterwards.
- start=0xFFFF_FFF0, step=0x20, stop=0xFFFF_FFFF → single point 0xFFFF_FFF0 (carry detected); no wrapped FTW is ever loaded.
- noise_en held low after LOAD, SETTLE_MAX=255 → err_timeout=1 at settle cycle 255, then IDLE; the next cfg_start clears it.
- Continuous mode, start=10, step=10, stop=30 → FTW sequence 10, 20, 30, 10, 20…; abort asserted in DWELL → IDLE next cycle, no sweep_done, ftw_out held.
- noise_en dropped for 2 cycles mid-DWELL → returns to SETTLE; the full dwell restarts; point_tick timing shifts accordingly.
- With DDS_TRIANGLE_SWEEP_EN: start=0, step=100, stop=300, single → FTW sequence 0, 100, 200, 300, 200, 100, 0, then sweep_done.
